// File: rtl/ram_sp_arbiter_pkg.sv
// Shared types for the single-port RAM arbiter.
//   NREQ        : number of requesters (fixed at 2)
//   owner_t     : requester index
//   owner_tag_t : {valid, owner} tag used for lock ownership and read return
package ram_sp_arbiter_pkg;

  localparam int NREQ = 2;

  typedef logic [0:0] owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } owner_tag_t;

  typedef owner_tag_t rd_tag_t;

  function automatic logic [NREQ-1:0] owner_onehot(input owner_t o);
    logic [NREQ-1:0] r;
    r    = '0;
    r[o] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/ram_sp_arbiter_if.sv
// Requester-side bus of the RAM arbiter.
//   req/lock/req_we : per-requester request, lock and write enable
//   req_addr        : requester i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata       : requester i write data at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt             : one-hot combinational grant
//   rvalid/rdata    : tagged read return, 2 cycles after the grant
// master = requester side, slave = arbiter side.
interface ram_sp_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  import ram_sp_arbiter_pkg::*;

  logic [NREQ-1:0]            req;
  logic [NREQ-1:0]            lock;
  logic [NREQ-1:0]            req_we;
  logic [NREQ*ADDR_WIDTH-1:0] req_addr;
  logic [NREQ*DATA_WIDTH-1:0] req_wdata;
  logic [NREQ-1:0]            gnt;
  logic [NREQ-1:0]            rvalid;
  logic [DATA_WIDTH-1:0]      rdata;

  modport master (
    output req, lock, req_we, req_addr, req_wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, lock, req_we, req_addr, req_wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/ram_sp_arbiter_rr_arbiter2.sv
// Pure two-way round-robin grant logic with lock override.
//   req        : request vector
//   last_gnt   : index granted most recently
//   lock_owner : requester holding the lock (valid=0 means none)
//   gnt        : one-hot grant
module rr_arbiter2
  import ram_sp_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  owner_t          last_gnt,
  input  owner_tag_t      lock_owner,
  output logic [NREQ-1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (lock_owner.valid && req[lock_owner.owner]) begin
      gnt = owner_onehot(lock_owner.owner);
    end else begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_gnt == 1'b1) ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
    end
  end

endmodule

// File: rtl/ram_sp_arbiter.sv
// Round-robin arbiter and sequencer sharing one single-port, 1-cycle
// synchronous-read RAM between two requesters, with lock for atomic RMW.
//   clk, rst     : clock, synchronous active-high reset
//   bus          : requester-side interface (slave modport)
//   ram_address  : RAM address
//   ram_data_in  : RAM write data
//   ram_we       : RAM write enable
//   ram_cs       : RAM chip select
//   ram_data_out : RAM read data (registered inside the RAM)
module ram_sp_arbiter
  import ram_sp_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_sp_arbiter_if.slave       bus,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_we,
  output logic                  ram_cs,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  owner_t                last_gnt_q,   last_gnt_d;
  owner_tag_t            lock_owner_q, lock_owner_d;
  rd_tag_t               rd_pend_q,    rd_pend_d;
  logic [NREQ-1:0]       rvalid_q,     rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q,      rdata_d;

  logic [NREQ-1:0] arb_gnt;
  logic [NREQ-1:0] gnt;
  owner_t          gnt_idx;

  rr_arbiter2 u_arb (
    .req        (bus.req),
    .last_gnt   (last_gnt_q),
    .lock_owner (lock_owner_q),
    .gnt        (arb_gnt)
  );

  // Grant and RAM mux; nothing is granted while reset is held.
  always_comb begin
    gnt         = rst ? '0 : arb_gnt;
    gnt_idx     = '0;
    ram_we      = 1'b0;
    ram_address = '0;
    ram_data_in = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gnt_idx     = owner_t'(i);
        ram_we      = bus.req_we[i];
        ram_address = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        ram_data_in = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    ram_cs = |gnt;
  end

  always_comb begin
    last_gnt_d   = last_gnt_q;
    // A locked owner that keeps req is always granted, so "no grant this
    // cycle" also covers the owner dropping req: the lock falls away.
    lock_owner_d = '0;
    if (|gnt) begin
      last_gnt_d         = gnt_idx;
      lock_owner_d.valid = bus.lock[gnt_idx];
      lock_owner_d.owner = gnt_idx;
    end

    rd_pend_d.valid = ram_cs & ~ram_we;
    rd_pend_d.owner = gnt_idx;

    rvalid_d = rd_pend_q.valid ? owner_onehot(rd_pend_q.owner) : '0;
    rdata_d  = rd_pend_q.valid ? ram_data_out : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q   <= owner_t'(1);
      lock_owner_q <= '0;
      rd_pend_q    <= '0;
      rvalid_q     <= '0;
      rdata_q      <= '0;
    end else begin
      last_gnt_q   <= last_gnt_d;
      lock_owner_q <= lock_owner_d;
      rd_pend_q    <= rd_pend_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
    end
  end

  assign bus.gnt    = gnt;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Directed bench for ram_sp_arbiter with a behavioural 1-cycle synchronous RAM.
module tb_ram_sp_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ram_address;
  logic [7:0] ram_data_in;
  logic       ram_we;
  logic       ram_cs;
  logic [7:0] ram_data_out;
  logic [7:0] mem [256];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_sp_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

  ram_sp_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_we       (ram_we),
    .ram_cs       (ram_cs),
    .ram_data_out (ram_data_out)
  );

  // RAM: registered read, data_out held on write cycles.
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_address] <= ram_data_in;
      else        ram_data_out     <= mem[ram_address];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] lk, input logic [1:0] we,
                       input logic [7:0] a0, input logic [7:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1);
    bus.req       = r;
    bus.lock      = lk;
    bus.req_we    = we;
    bus.req_addr  = {a1, a0};
    bus.req_wdata = {d1, d0};
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic check_ret(input string tag, input logic [1:0] rv, input logic [7:0] rd);
    check_eq({tag, "_rvalid"}, bus.rvalid, rv);
    check_eq({tag, "_rdata"},  bus.rdata,  rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h05]   = 8'h11;
    mem[8'h0A]   = 8'h22;
    mem[8'h40]   = 8'h99;
    ram_data_out = 8'h00;

    // Reset with contention pending
    rst = 1'b1;
    drive(2'b11, 2'b00, 2'b00, 8'h05, 8'h0A, 8'h00, 8'h00);
    advance(); advance();
    settle();
    check_eq("rst_gnt", bus.gnt, 2'b00);
    check_eq("rst_cs", ram_cs, 1'b0);
    check_eq("rst_we", ram_we, 1'b0);
    check_ret("rst", 2'b00, 8'h00);

    // Round robin on two reads
    advance(); rst = 1'b0;
    settle();
    check_eq("rr1_gnt", bus.gnt, 2'b01);
    check_eq("rr1_cs", ram_cs, 1'b1);
    check_eq("rr1_addr", ram_address, 8'h05);
    check_eq("rr1_we", ram_we, 1'b0);
    advance(); settle();
    check_eq("rr2_gnt", bus.gnt, 2'b10);
    check_eq("rr2_addr", ram_address, 8'h0A);
    check_eq("rr2_rvalid", bus.rvalid, 2'b00);
    advance(); settle();
    check_eq("rr3_gnt", bus.gnt, 2'b01);
    check_ret("rr3", 2'b01, 8'h11);
    advance(); drive(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00); settle();
    check_eq("rr4_gnt", bus.gnt, 2'b00);
    check_eq("rr4_cs", ram_cs, 1'b0);
    check_eq("rr4_addr", ram_address, 8'h00);
    check_ret("rr4", 2'b10, 8'h22);
    advance(); settle();
    check_ret("rr5", 2'b01, 8'h11);

    // Requester 1 alone, so requester 0 wins the next contention
    advance(); drive(2'b10, 2'b00, 2'b00, 8'h00, 8'h0A, 8'h00, 8'h00); settle();
    check_eq("solo_gnt", bus.gnt, 2'b10);
    check_eq("solo_rvalid", bus.rvalid, 2'b00);

    // Write 0x3C to 0x20 by r0 against read of 0x20 by r1
    advance(); drive(2'b11, 2'b00, 2'b01, 8'h20, 8'h20, 8'h3C, 8'h00); settle();
    check_eq("wr_gnt", bus.gnt, 2'b01);
    check_eq("wr_we", ram_we, 1'b1);
    check_eq("wr_addr", ram_address, 8'h20);
    check_eq("wr_din", ram_data_in, 8'h3C);
    advance(); drive(2'b10, 2'b00, 2'b00, 8'h00, 8'h20, 8'h00, 8'h00); settle();
    check_eq("rdw_gnt", bus.gnt, 2'b10);
    check_eq("rdw_we", ram_we, 1'b0);
    check_ret("rdw", 2'b10, 8'h22);
    advance(); drive(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00); settle();
    check_ret("wr_norv", 2'b00, 8'h22);
    advance(); settle();
    check_ret("rdw_ret", 2'b10, 8'h3C);

    // Atomic RMW on 0x40 by r0 while r1 keeps requesting
    advance(); drive(2'b11, 2'b01, 2'b00, 8'h40, 8'h05, 8'h00, 8'h00); settle();
    check_eq("rmw_rd_gnt", bus.gnt, 2'b01);
    check_eq("rmw_rd_addr", ram_address, 8'h40);
    advance(); drive(2'b11, 2'b00, 2'b01, 8'h40, 8'h05, 8'h41, 8'h00); settle();
    check_eq("rmw_wr_gnt", bus.gnt, 2'b01);
    check_eq("rmw_wr_we", ram_we, 1'b1);
    check_eq("rmw_wr_din", ram_data_in, 8'h41);
    advance(); drive(2'b11, 2'b00, 2'b00, 8'h40, 8'h05, 8'h00, 8'h00); settle();
    check_eq("rmw_after_gnt", bus.gnt, 2'b10);
    check_eq("rmw_after_addr", ram_address, 8'h05);
    check_ret("rmw_old", 2'b01, 8'h99);
    advance(); drive(2'b01, 2'b00, 2'b00, 8'h40, 8'h00, 8'h00, 8'h00); settle();
    check_eq("rmw_rb_gnt", bus.gnt, 2'b01);
    check_eq("rmw_rb_rvalid", bus.rvalid, 2'b00);
    advance(); drive(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00); settle();
    check_ret("rmw_r1", 2'b10, 8'h11);
    advance(); settle();
    check_ret("rmw_new", 2'b01, 8'h41);

    // Idle with lock but no request
    drive(2'b00, 2'b11, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 10; i++) begin
      advance(); settle();
      check_eq("idle_gnt", bus.gnt, 2'b00);
      check_eq("idle_cs", ram_cs, 1'b0);
      check_ret("idle", 2'b00, 8'h41);
    end

    // Reset one cycle after a granted locked read
    advance(); drive(2'b01, 2'b01, 2'b00, 8'h05, 8'h0A, 8'h00, 8'h00); settle();
    check_eq("pre_rst_gnt", bus.gnt, 2'b01);
    advance(); rst = 1'b1; drive(2'b11, 2'b00, 2'b00, 8'h05, 8'h0A, 8'h00, 8'h00); settle();
    check_eq("mid_rst_gnt", bus.gnt, 2'b00);
    check_eq("mid_rst_cs", ram_cs, 1'b0);
    advance(); settle();
    check_eq("mid_rst2_gnt", bus.gnt, 2'b00);
    check_ret("mid_rst2", 2'b00, 8'h00);
    advance(); rst = 1'b0; settle();
    check_eq("post_rst_gnt", bus.gnt, 2'b01);
    check_eq("post_rst_rvalid", bus.rvalid, 2'b00);
    advance(); settle();
    check_eq("post_rst2_gnt", bus.gnt, 2'b10);
    check_eq("post_rst2_rvalid", bus.rvalid, 2'b00);
    advance(); drive(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00); settle();
    check_ret("post_rst_r0", 2'b01, 8'h11);
    advance(); settle();
    check_ret("post_rst_r1", 2'b10, 8'h22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_sp_arbiter.md
Name: ram_sp_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for one single-port, synchronous-read RAM in the LDPC decoder. The RAM has address, data_in, we, cs, data_out, and a read latency of 1 cycle.
- Lets the variable-node and check-node update units share one message memory.
- Returns read data to the requester that issued the read, tagged and cycle-exact.
- Supports a lock so a requester can do an atomic read-modify-write.

Parameters:
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 8, RAM address width.
- NREQ, 2, number of requesters; fixed at 2 in this revision.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  2  per-requester access request.
- lock  in  2  per-requester: keep the grant next cycle while req stays high.
- req_we  in  2  per-requester write enable (1 = write, 0 = read).
- req_addr  in  2*ADDR_WIDTH  requester i address at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  2*DATA_WIDTH  requester i write data, packed the same way.
- gnt  out  2  one-hot grant, combinational this cycle.
- rvalid  out  2  one-cycle pulse: read data for requester i is on rdata.
- rdata  out  DATA_WIDTH  registered copy of RAM data_out.
- ram_address  out  ADDR_WIDTH  to RAM address.
- ram_data_in  out  DATA_WIDTH  to RAM data_in.
- ram_we  out  1  to RAM we.
- ram_cs  out  1  to RAM cs.
- ram_data_out  in  DATA_WIDTH  from RAM data_out.

Behaviour:
- Reset (rst=1 at posedge):
  - last_gnt <= 1, so requester 0 wins first; lock_owner <= none.
  - rd_pend <= 0; rvalid <= 0; rdata <= 0.
  - While rst=1: gnt=0, ram_cs=0, ram_we=0.
- Arbitration (combinational):
  - If lock_owner=i and req[i]=1: gnt[i]=1.
  - Else if only one req is high: grant it.
  - Else if both are high: grant the one not equal to last_gnt.
  - No req: gnt=0 and ram_cs=0.
- RAM drive:
  - ram_cs = |gnt.
  - ram_we, ram_address and ram_data_in are muxed from the granted requester.
  - With no grant, address and data are 0.
- A transfer occurs when gnt[i]=1. The requester must hold req and its fields stable until it sees gnt. No transfer is dropped.
- State update on each granted cycle:
  - last_gnt <= i.
  - lock_owner <= i if lock[i]=1, else none.
  - lock_owner also clears when the owner drops req.
- Read return:
  - Granted read at cycle T: the RAM registers data_out at T+1.
  - Stage 1: rd_pend <= {valid, owner} at T+1.
  - Stage 2: rdata <= ram_data_out and rvalid[owner] <= 1 at T+2.
  - Read latency from grant to rvalid is therefore 2 cycles, fully pipelined: back-to-back reads give back-to-back rvalid.
- Writes produce no rvalid. The RAM holds data_out on write cycles; rdata updates only on rvalid cycles.
- A lock with no request is ignored. A lock can starve the other requester; preventing that is the users' responsibility.
- Simultaneous events:
  - A write followed by a read of the same address in the next cycle returns the new data (RAM write-first across cycles).
  - Both requesters writing at once: only the granted write occurs.
- Reset mid-operation: in-flight read returns are discarded (no rvalid) and the lock is released.

Decomposition:
- A shared package holds:
  - localparam NREQ = 2.
  - The owner-index type.
  - The read-return tag struct {valid, owner}.
- The RAM itself stays a separate instance at the level above.
- One natural sub-module: rr_arbiter2, the pure round-robin grant logic (req, last_gnt, lock_owner -> gnt).

Test Plan:
- Reset, then req=2'b11, both reads, addr0=0x05, addr1=0x0A, RAM preloaded [5]=0x11, [10]=0x22 -> gnt sequence 01,10,01.
  - rvalid[0] with rdata=0x11 two cycles after the first grant.
  - rvalid[1] with rdata=0x22 next cycle.
- Requester 0 writes 0x3C to 0x20 while requester 1 reads 0x20 in the same cycle -> write granted first.
  - Read granted next cycle; rvalid[1] with rdata=0x3C.
- Atomic RMW: requester 0 reads 0x40 with lock=1 while req1 is high.
  - Next cycle requester 0 writes 0x41 with lock=0 -> gnt stays 01 for both cycles, then 10.
  - A subsequent read of 0x40 returns 0x41.
- Idle: req=0 for 10 cycles -> ram_cs=0, gnt=0, rvalid=0, and rdata holds its last value.
- Assert rst one cycle after a granted read -> no rvalid afterwards.
  - gnt=0 and ram_cs=0 during rst.
  - After rst the first contention is granted to requester 0.
